// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one cache port between two requesters,
// with saturating per-requester attempt and hit counters.
module cache_arbiter #(
   parameter int ADDR_W = 15,
   parameter int CNT_W  = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   output logic              done0,
   output logic              done1,
   output logic              hit0,
   output logic              hit1,
   input  logic              cache_ready,
   input  logic              cache_hit,
   output logic              cache_read,
   output logic              cache_write,
   output logic [ADDR_W-1:0] address,
   input  logic              stats_clr,
   output logic [CNT_W-1:0]  attempts0,
   output logic [CNT_W-1:0]  attempts1,
   output logic [CNT_W-1:0]  hits0,
   output logic [CNT_W-1:0]  hits1
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_gnt;
   logic                r_last_gnt;
   logic                r_read;
   logic                r_write;
   logic [ADDR_W-1:0]   r_address;
   logic                r_done0;
   logic                r_done1;
   logic                r_hit0;
   logic                r_hit1;
   logic [CNT_W-1:0]    r_att0;
   logic [CNT_W-1:0]    r_att1;
   logic [CNT_W-1:0]    r_hcnt0;
   logic [CNT_W-1:0]    r_hcnt1;

   logic                w_any;
   logic                w_sel;
   logic                w_we;
   logic                w_gnt_nxt;
   logic                w_last_nxt;
   logic                w_read_nxt;
   logic                w_write_nxt;
   logic [ADDR_W-1:0]   w_addr_nxt;
   logic                w_done0_nxt;
   logic                w_done1_nxt;
   logic                w_hit0_nxt;
   logic                w_hit1_nxt;
   logic                w_inc;

   function automatic logic [CNT_W-1:0] sat_inc(
      input logic [CNT_W-1:0] v
   );
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // On a tie, the requester that did not win last time gets the port
   assign w_any = req0 | req1;
   assign w_sel = (req0 & req1) ? ~r_last_gnt : req1;
   assign w_we  = w_sel ? we1 : we0;

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_last_nxt  = r_last_gnt;
      w_read_nxt  = r_read;
      w_write_nxt = r_write;
      w_addr_nxt  = r_address;
      w_done0_nxt = 1'b0;
      w_done1_nxt = 1'b0;
      w_hit0_nxt  = 1'b0;
      w_hit1_nxt  = 1'b0;
      w_inc       = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_gnt_nxt   = w_sel;
               w_addr_nxt  = w_sel ? addr1 : addr0;
               w_read_nxt  = ~w_we;
               w_write_nxt = w_we;
               w_state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (cache_ready) begin
               w_read_nxt  = 1'b0;
               w_write_nxt = 1'b0;
               w_done0_nxt = ~r_gnt;
               w_done1_nxt = r_gnt;
               w_hit0_nxt  = ~r_gnt & cache_hit;
               w_hit1_nxt  = r_gnt & cache_hit;
               w_last_nxt  = r_gnt;
               w_inc       = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_gnt      <= 1'b0;
         r_last_gnt <= 1'b1;
         r_read     <= 1'b0;
         r_write    <= 1'b0;
         r_address  <= '0;
         r_done0    <= 1'b0;
         r_done1    <= 1'b0;
         r_hit0     <= 1'b0;
         r_hit1     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_gnt      <= w_gnt_nxt;
         r_last_gnt <= w_last_nxt;
         r_read     <= w_read_nxt;
         r_write    <= w_write_nxt;
         r_address  <= w_addr_nxt;
         r_done0    <= w_done0_nxt;
         r_done1    <= w_done1_nxt;
         r_hit0     <= w_hit0_nxt;
         r_hit1     <= w_hit1_nxt;
      end
   end

   // A clear in the same cycle as a completion takes priority
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_att0  <= '0;
         r_att1  <= '0;
         r_hcnt0 <= '0;
         r_hcnt1 <= '0;
      end else if (stats_clr) begin
         r_att0  <= '0;
         r_att1  <= '0;
         r_hcnt0 <= '0;
         r_hcnt1 <= '0;
      end else if (w_inc) begin
         if (r_gnt) begin
            r_att1 <= sat_inc(r_att1);
            if (cache_hit) r_hcnt1 <= sat_inc(r_hcnt1);
         end else begin
            r_att0 <= sat_inc(r_att0);
            if (cache_hit) r_hcnt0 <= sat_inc(r_hcnt0);
         end
      end
   end

   assign done0       = r_done0;
   assign done1       = r_done1;
   assign hit0        = r_hit0;
   assign hit1        = r_hit1;
   assign cache_read  = r_read;
   assign cache_write = r_write;
   assign address     = r_address;
   assign attempts0   = r_att0;
   assign attempts1   = r_att1;
   assign hits0       = r_hcnt0;
   assign hits1       = r_hcnt1;

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-port arbiter sharing the single direct-mapped cache between two requesters (e.g. two address-sequence generators). It grants one request at a time under round-robin priority. It drives the cache's `cache_read`/`cache_write`/`address` strobes and holds them until `cache_ready`. It also keeps saturating per-requester attempt and hit counters for hit-rate reporting.

## Interface
- `ADDR_W`, 15, width of cache address
- `CNT_W`, 14, width of each statistics counter
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `req0`, `req1`  in  1  access request from requester 0 / 1
- `we0`, `we1`  in  1  1 = write, 0 = read; valid while reqN high
- `addr0`, `addr1`  in  ADDR_W  request address; valid while reqN high
- `done0`, `done1`  out  1  one-cycle completion pulse to requester
- `hit0`, `hit1`  out  1  hit flag for completed access, valid with doneN
- `cache_ready`  in  1  cache completion strobe for the current access
- `cache_hit`  in  1  hit indicator, sampled only with `cache_ready`
- `cache_read`, `cache_write`  out  1  cache strobes, mutually exclusive
- `address`  out  ADDR_W  cache address
- `stats_clr`  in  1  synchronous clear of all counters
- `attempts0`, `attempts1`, `hits0`, `hits1`  out  CNT_W  statistics

## Operation
- FSM states are IDLE, BUSY and DONE. All outputs are registered.
- IDLE: sample `req0`/`req1`.
  - None set: stay in IDLE.
  - One set: grant it.
  - Both set: grant the requester not granted last (`last_gnt` register).
  - On grant: latch the granted requester's address and we into `address` and the op register, set `cache_read` = ~we or `cache_write` = we, and go to BUSY.
- BUSY: hold the strobe and `address` constant.
  - On `cache_ready` = 1: clear the strobe, set `doneN` and `hitN` = `cache_hit` for the granted requester, update `last_gnt`, increment `attemptsN`, increment `hitsN` if `cache_hit` = 1, then go to DONE.
- DONE: `doneN` is high for this cycle only. Return to IDLE unconditionally. Requests are not sampled in DONE.
- Requester protocol:
  - Hold `reqN`/`weN`/`addrN` stable until `doneN` is seen.
  - Deassert `reqN`, or present the next request, on the edge that samples `doneN`.
- A requester dropping `reqN` while BUSY does not abort the access. It still completes and `doneN` still pulses.
- `cache_ready` outside BUSY is ignored; no counters change.
- Counters saturate at all-ones and never wrap.
- `stats_clr` zeros all four counters. `stats_clr` and an increment in the same cycle: clear wins, result is 0.
- Reset values (asserted when `rst` = 0, independent of `clk`):
  - state = IDLE
  - `cache_read` = `cache_write` = 0, `address` = 0
  - `done*` = `hit*` = 0
  - all counters = 0
  - `last_gnt` = 1, so requester 0 wins the first tie
- Reset mid-BUSY abandons the cache access; no `doneN` is issued.

## Timing
- Grant latency: a request sampled at IDLE edge t makes the strobe and `address` valid immediately after edge t.
- Completion: `cache_ready` sampled at edge t+k drops the strobe after t+k, and `doneN` is high during cycle t+k..t+k+1.
- Counters reflect the access after edge t+k.
- Minimum access cost is 3 cycles (IDLE, BUSY with `cache_ready` already high, DONE).
- Back-to-back requests from one requester take ≥3 cycles each.
- Under contention, grants strictly alternate 0,1,0,1.
- `cache_read` and `cache_write` are never both 1. Neither is 1 outside BUSY.
- `address` changes only on the IDLE→BUSY transition.

## Test plan
- Reset, then req0 read addr 0x0400 with `cache_ready` held 1. Required: `cache_read` = 1 and `address` = 0x0400 for exactly 1 cycle, then `done0` pulse, then `attempts0` = 1.
- Both requesters requesting continuously: req0 read 0x0010 and req1 write 0x0020, `cache_ready` asserted after 2 BUSY cycles.
  - Grant order 0,1,0,1.
  - `cache_write` = 1 only during requester-1 grants.
  - After 4 accesses, `attempts0` = `attempts1` = 2.
- `cache_hit` pattern 1,0,1 with `cache_ready` on req0. Required: `hits0` = 2, `attempts0` = 3, `hit0` matches each `cache_hit` value at its `done0` pulse.
- Force `attempts0` to 2^CNT_W−1 via 16383 accesses, then perform one more. Required: `attempts0` stays 16383. Pulse `stats_clr` together with a completing access: all counters = 0.
- Pulse `rst` = 0 while BUSY. Required: `cache_read` = 0 immediately, no `done0`, counters = 0. After release, the next tie grants requester 0.
- Pulse `cache_ready` while IDLE with no requests. Required: no `done`, no counter change, state stays IDLE.
